// File: rtl/enemy_gunner.sv
// enemy_gunner: the enemy aims at the player, fires one bullet at a time and tracks player health/lives.
// Latency: one state update per frame_clk edge; bullet moves BULLET_SPEED pixels per frame.
// Backpressure: none; the block free-runs every frame. Optional ENEMY_GUNNER_INVULN_EN adds a post-hit invulnerability window.
module enemy_gunner #(
  parameter int MAX_X           = 640,
  parameter int MAX_Y           = 480,
  parameter int BULLET_WIDTH    = 4,
  parameter int BULLET_HEIGHT   = 2,
  parameter int BULLET_SPEED    = 6,
  parameter int MUZZLE_DY       = 6,
  parameter int AIM_FRAMES      = 8,
  parameter int COOLDOWN_FRAMES = 30,
  parameter int MAX_HEALTH      = 10,
  parameter int MAX_LIVES       = 3
`ifdef ENEMY_GUNNER_INVULN_EN
  ,
  parameter int INVULN_FRAMES   = 60
`endif
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       new_level,
  input  logic [9:0] EnemyX,
  input  logic [9:0] EnemyY,
  input  logic [9:0] EnemyW,
  input  logic [9:0] EnemyH,
  input  logic [9:0] EnemyLives,
  input  logic [9:0] PlayerX,
  input  logic [9:0] PlayerY,
  input  logic [9:0] PlayerW,
  input  logic [9:0] PlayerH,
  output logic [9:0] BulletX,
  output logic [9:0] BulletY,
  output logic [9:0] BulletW,
  output logic [9:0] BulletH,
  output logic [9:0] PlayerHealth,
  output logic [9:0] PlayerLives,
  output logic       GameOver,
  output logic       Firing
`ifdef ENEMY_GUNNER_INVULN_EN
  ,
  output logic       PlayerInvuln
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_AIM, S_FLIGHT, S_COOL, S_DEAD} state_t;

  state_t             r_state, w_state_nxt;
  logic signed [31:0] r_cnt, r_bx, r_by, r_health, r_lives;
  logic signed [31:0] w_cnt_nxt, w_bx_nxt, w_by_nxt, w_health_nxt, w_lives_nxt;
  logic               r_left, w_left_nxt;
  logic               w_dmg;
  logic               w_invuln;

  // All geometry is done in signed 32-bit so the left-edge test never wraps.
  logic signed [31:0] w_ex, w_ey, w_ew, w_px, w_py, w_pw, w_ph;
  logic signed [31:0] w_muzzle_y, w_step_x, w_lead_x;
  logic               w_aligned, w_aim_left, w_at_edge, w_hit;

  assign w_ex = signed'({22'd0, EnemyX});
  assign w_ey = signed'({22'd0, EnemyY});
  assign w_ew = signed'({22'd0, EnemyW});
  assign w_px = signed'({22'd0, PlayerX});
  assign w_py = signed'({22'd0, PlayerY});
  assign w_pw = signed'({22'd0, PlayerW});
  assign w_ph = signed'({22'd0, PlayerH});

  assign w_muzzle_y = w_ey + MUZZLE_DY;
  assign w_aligned  = (w_py < w_muzzle_y) && (w_muzzle_y < w_py + w_ph);
  assign w_aim_left = (w_px + w_pw / 2) < (w_ex + w_ew / 2);

  // Direction and Y are latched at spawn; only the X step uses live registers.
  assign w_at_edge = r_left ? (r_bx < BULLET_SPEED)
                            : (r_bx + BULLET_WIDTH + BULLET_SPEED >= MAX_X);
  assign w_step_x  = r_left ? (r_bx - BULLET_SPEED) : (r_bx + BULLET_SPEED);
  assign w_lead_x  = r_left ? w_step_x : (w_step_x + BULLET_WIDTH - 1);
  assign w_hit     = (w_px < w_lead_x) && (w_lead_x < w_px + w_pw) &&
                     (w_py < r_by) && (r_by < w_py + w_ph);

`ifdef ENEMY_GUNNER_INVULN_EN
  logic signed [31:0] r_inv_cnt;
  assign w_invuln     = (r_inv_cnt != 0);
  assign PlayerInvuln = w_invuln;

  // Invulnerability window: reloaded on every damaging hit, counts down regardless of gunner state.
  always_ff @(posedge frame_clk) begin
    if (!Reset || new_level) r_inv_cnt <= '0;
    else if (w_dmg)          r_inv_cnt <= INVULN_FRAMES;
    else if (r_inv_cnt != 0) r_inv_cnt <= r_inv_cnt - 1;
  end
`else
  assign w_invuln = 1'b0;
`endif

  // State and datapath registers; Reset and new_level restore the same start-of-level values.
  always_ff @(posedge frame_clk) begin
    if (!Reset || new_level) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bx     <= MAX_X;
      r_by     <= MAX_Y;
      r_left   <= 1'b0;
      r_health <= MAX_HEALTH;
      r_lives  <= MAX_LIVES;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bx     <= w_bx_nxt;
      r_by     <= w_by_nxt;
      r_left   <= w_left_nxt;
      r_health <= w_health_nxt;
      r_lives  <= w_lives_nxt;
    end
  end

  // Next-state logic: a dead enemy overrides everything except the DEAD state.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_bx_nxt     = r_bx;
    w_by_nxt     = r_by;
    w_left_nxt   = r_left;
    w_health_nxt = r_health;
    w_lives_nxt  = r_lives;
    w_dmg        = 1'b0;
    if (r_state != S_DEAD && EnemyLives == 10'd0) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_bx_nxt    = MAX_X;
      w_by_nxt    = MAX_Y;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_bx_nxt = MAX_X;
          w_by_nxt = MAX_Y;
          if (w_aligned) begin
            w_state_nxt = S_AIM;
            w_cnt_nxt   = '0;
          end
        end
        S_AIM: begin
          if (!w_aligned) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == AIM_FRAMES - 1) begin
            w_state_nxt = S_FLIGHT;
            w_cnt_nxt   = '0;
            w_left_nxt  = w_aim_left;
            w_bx_nxt    = w_aim_left ? (w_ex - BULLET_WIDTH) : (w_ex + w_ew);
            w_by_nxt    = w_muzzle_y;
          end else begin
            w_cnt_nxt = r_cnt + 1;
          end
        end
        S_FLIGHT: begin
          if (w_at_edge || w_hit) begin
            w_bx_nxt    = MAX_X;
            w_by_nxt    = MAX_Y;
            w_state_nxt = S_COOL;
            w_cnt_nxt   = '0;
            if (!w_at_edge && !w_invuln) begin
              w_dmg = 1'b1;
              if (r_health == 1) begin
                w_health_nxt = MAX_HEALTH;
                w_lives_nxt  = r_lives - 1;
                if (r_lives == 1) w_state_nxt = S_DEAD;
              end else begin
                w_health_nxt = r_health - 1;
              end
            end
          end else begin
            w_bx_nxt = w_step_x;
          end
        end
        S_COOL: begin
          w_bx_nxt = MAX_X;
          w_by_nxt = MAX_Y;
          if (r_cnt == COOLDOWN_FRAMES - 1) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1;
          end
        end
        default: begin
          w_bx_nxt = MAX_X;
          w_by_nxt = MAX_Y;
        end
      endcase
    end
  end

  // State-decoded status flags.
  always_comb begin
    GameOver = (r_state == S_DEAD);
    Firing   = (r_state == S_FLIGHT);
  end

  assign BulletX      = r_bx[9:0];
  assign BulletY      = r_by[9:0];
  assign BulletW      = 10'(BULLET_WIDTH);
  assign BulletH      = 10'(BULLET_HEIGHT);
  assign PlayerHealth = r_health[9:0];
  assign PlayerLives  = r_lives[9:0];

  logic w_unused;
  assign w_unused = ^{r_bx[31:10], r_by[31:10], r_health[31:10], r_lives[31:10], EnemyH};

endmodule

// File: tb/tb_enemy_gunner.sv
// tb_enemy_gunner: scenario tasks push expected snapshots to a scoreboard and pop them when the DUT responds.
// Timing: inputs driven and outputs sampled 1 time unit after each rising frame_clk edge.
// Every wait on a DUT event is bounded; an expired bound is reported as a failure.
module tb_enemy_gunner;

  logic       frame_clk = 1'b0;
  logic       Reset, new_level;
  logic [9:0] EnemyX, EnemyY, EnemyW, EnemyH, EnemyLives;
  logic [9:0] PlayerX, PlayerY, PlayerW, PlayerH;
  logic [9:0] BulletX, BulletY, BulletW, BulletH, PlayerHealth, PlayerLives;
  logic       GameOver, Firing;
`ifdef ENEMY_GUNNER_INVULN_EN
  logic       PlayerInvuln;
`endif

  int checks = 0;
  int errors = 0;
  int frame_no = 0;

  typedef struct packed {
    logic [9:0] bx;
    logic [9:0] by;
    logic [9:0] health;
    logic [9:0] lives;
    logic       go;
    logic       fire;
  } snap_t;

  snap_t sb_q[$];
  snap_t exp_s, obs_s;

  always #5 frame_clk = ~frame_clk;

  enemy_gunner dut (
    .frame_clk(frame_clk), .Reset(Reset), .new_level(new_level),
    .EnemyX(EnemyX), .EnemyY(EnemyY), .EnemyW(EnemyW), .EnemyH(EnemyH),
    .EnemyLives(EnemyLives),
    .PlayerX(PlayerX), .PlayerY(PlayerY), .PlayerW(PlayerW), .PlayerH(PlayerH),
    .BulletX(BulletX), .BulletY(BulletY), .BulletW(BulletW), .BulletH(BulletH),
    .PlayerHealth(PlayerHealth), .PlayerLives(PlayerLives),
    .GameOver(GameOver), .Firing(Firing)
`ifdef ENEMY_GUNNER_INVULN_EN
    , .PlayerInvuln(PlayerInvuln)
`endif
  );

  function automatic snap_t mk(input int bx, input int by, input int h, input int l,
                               input int go, input int fire);
    snap_t s;
    s.bx = 10'(bx); s.by = 10'(by); s.health = 10'(h); s.lives = 10'(l);
    s.go = (go != 0); s.fire = (fire != 0);
    return s;
  endfunction

  function automatic snap_t obs_now();
    snap_t s;
    s.bx = BulletX; s.by = BulletY; s.health = PlayerHealth; s.lives = PlayerLives;
    s.go = GameOver; s.fire = Firing;
    return s;
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("bx=%0d by=%0d hp=%0d lives=%0d go=%0b fire=%0b",
                     s.bx, s.by, s.health, s.lives, s.go, s.fire);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge frame_clk);
      #1;
      frame_no++;
    end
  endtask

  // Holds Reset low for one edge with the given geometry applied, then releases it.
  task automatic setup(input int ex, input int ey, input int px, input int py);
    Reset = 1'b0; new_level = 1'b0;
    EnemyX = 10'(ex); EnemyY = 10'(ey); EnemyW = 10'd20; EnemyH = 10'd20;
    PlayerX = 10'(px); PlayerY = 10'(py); PlayerW = 10'd20; PlayerH = 10'd20;
    EnemyLives = 10'd3;
    tick(1);
    Reset = 1'b1;
  endtask

  // Advances until Firing equals lvl, at most 100 edges; ok reports success.
  task automatic wait_level(input logic lvl, output bit ok);
    int t = 0;
    while (Firing !== lvl && t < 100) begin
      tick(1);
      t++;
    end
    ok = (Firing === lvl);
  endtask

  task automatic test_reset();
    EnemyX = 10'd0; EnemyY = 10'd0; EnemyW = 10'd0; EnemyH = 10'd0; EnemyLives = 10'd0;
    PlayerX = 10'd0; PlayerY = 10'd0; PlayerW = 10'd0; PlayerH = 10'd0;
    Reset = 1'b0; new_level = 1'b0;
    sb_q.push_back(mk(640, 480, 10, 3, 0, 0));
    tick(1);
    exp_s = sb_q.pop_front(); obs_s = obs_now(); checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL reset: got %s want %s", fmt(obs_s), fmt(exp_s)); end
    checks++;
    if ({BulletW, BulletH} !== {10'd4, 10'd2}) begin
      errors++; $display("FAIL bullet_size: got %0d x %0d want 4 x 2", BulletW, BulletH);
    end
  endtask

  task automatic test_left_hit();
    setup(300, 200, 100, 195);
    sb_q.push_back(mk(640, 480, 10, 3, 0, 0));
    tick(8);
    exp_s = sb_q.pop_front(); obs_s = obs_now(); checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL aim_wait: got %s want %s", fmt(obs_s), fmt(exp_s)); end
    sb_q.push_back(mk(296, 206, 10, 3, 0, 1));
    tick(1);
    exp_s = sb_q.pop_front(); obs_s = obs_now(); checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL spawn_left: got %s want %s", fmt(obs_s), fmt(exp_s)); end
    sb_q.push_back(mk(122, 206, 10, 3, 0, 1));
    tick(29);
    exp_s = sb_q.pop_front(); obs_s = obs_now(); checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL flight29: got %s want %s", fmt(obs_s), fmt(exp_s)); end
    sb_q.push_back(mk(640, 480, 9, 3, 0, 0));
    tick(1);
    exp_s = sb_q.pop_front(); obs_s = obs_now(); checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL hit_left: got %s want %s", fmt(obs_s), fmt(exp_s)); end
    // 30 cooldown frames, then one IDLE->AIM edge and 8 more aiming edges.
    sb_q.push_back(mk(640, 480, 9, 3, 0, 0));
    tick(38);
    exp_s = sb_q.pop_front(); obs_s = obs_now(); checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL cooldown_hold: got %s want %s", fmt(obs_s), fmt(exp_s)); end
    sb_q.push_back(mk(296, 206, 9, 3, 0, 1));
    tick(1);
    exp_s = sb_q.pop_front(); obs_s = obs_now(); checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL respawn: got %s want %s", fmt(obs_s), fmt(exp_s)); end
  endtask

  task automatic test_aim_abort();
    setup(300, 200, 100, 195);
    tick(4);
    PlayerY = 10'd300;
    sb_q.push_back(mk(640, 480, 10, 3, 0, 0));
    tick(3);
    exp_s = sb_q.pop_front(); obs_s = obs_now(); checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL abort_idle: got %s want %s", fmt(obs_s), fmt(exp_s)); end
    PlayerY = 10'd195;
    sb_q.push_back(mk(640, 480, 10, 3, 0, 0));
    tick(8);
    exp_s = sb_q.pop_front(); obs_s = obs_now(); checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL realign_wait: got %s want %s", fmt(obs_s), fmt(exp_s)); end
    sb_q.push_back(mk(296, 206, 10, 3, 0, 1));
    tick(1);
    exp_s = sb_q.pop_front(); obs_s = obs_now(); checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL realign_spawn: got %s want %s", fmt(obs_s), fmt(exp_s)); end
  endtask

  task automatic test_right_edge();
    setup(560, 200, 620, 195);
    sb_q.push_back(mk(580, 206, 10, 3, 0, 1));
    tick(9);
    exp_s = sb_q.pop_front(); obs_s = obs_now(); checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL spawn_right: got %s want %s", fmt(obs_s), fmt(exp_s)); end
    // Player steps out of the path; enemy moves too, which must not disturb the latched Y.
    PlayerY = 10'd300;
    EnemyY  = 10'd100;
    for (int k = 1; k <= 9; k++) begin
      sb_q.push_back(mk(580 + 6 * k, 206, 10, 3, 0, 1));
      tick(1);
      exp_s = sb_q.pop_front(); obs_s = obs_now(); checks++;
      if (obs_s !== exp_s) begin errors++; $display("FAIL right_step%0d: got %s want %s", k, fmt(obs_s), fmt(exp_s)); end
    end
    // 634 + 4 + 6 >= 640: parked, no damage.
    sb_q.push_back(mk(640, 480, 10, 3, 0, 0));
    tick(1);
    exp_s = sb_q.pop_front(); obs_s = obs_now(); checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL right_park: got %s want %s", fmt(obs_s), fmt(exp_s)); end
  endtask

  task automatic test_enemy_dead();
    setup(300, 200, 100, 195);
    tick(14);
    EnemyLives = 10'd0;
    sb_q.push_back(mk(640, 480, 10, 3, 0, 0));
    tick(1);
    exp_s = sb_q.pop_front(); obs_s = obs_now(); checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL enemy_dead_park: got %s want %s", fmt(obs_s), fmt(exp_s)); end
    sb_q.push_back(mk(640, 480, 10, 3, 0, 0));
    tick(20);
    exp_s = sb_q.pop_front(); obs_s = obs_now(); checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL enemy_dead_hold: got %s want %s", fmt(obs_s), fmt(exp_s)); end
    EnemyLives = 10'd3;
    sb_q.push_back(mk(640, 480, 10, 3, 0, 0));
    tick(8);
    exp_s = sb_q.pop_front(); obs_s = obs_now(); checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL revive_wait: got %s want %s", fmt(obs_s), fmt(exp_s)); end
    sb_q.push_back(mk(296, 206, 10, 3, 0, 1));
    tick(1);
    exp_s = sb_q.pop_front(); obs_s = obs_now(); checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL revive_spawn: got %s want %s", fmt(obs_s), fmt(exp_s)); end
  endtask

  task automatic test_game_over();
    int  exp_h = 10;
    int  exp_l = 3;
    int  hits = 0;
    int  seen = 0;
    int  last_dmg = -1000;
    bit  ok;
    bit  dmg;
    setup(300, 200, 260, 195);
    while (exp_l > 0 && hits < 100) begin
      wait_level(1'b1, ok);
      if (!ok) begin checks++; errors++; $display("FAIL go_spawn_timeout: got fire=%0b want 1", Firing); break; end
      wait_level(1'b0, ok);
      if (!ok) begin checks++; errors++; $display("FAIL go_hit_timeout: got fire=%0b want 0", Firing); break; end
      hits++;
      dmg = 1'b1;
`ifdef ENEMY_GUNNER_INVULN_EN
      dmg = (frame_no - last_dmg >= 60);
`endif
      if (dmg) begin
        last_dmg = frame_no;
        exp_h--;
        if (exp_h == 0) begin exp_l--; exp_h = 10; end
      end
      sb_q.push_back(mk(640, 480, exp_h, exp_l, (exp_l == 0) ? 1 : 0, 0));
      exp_s = sb_q.pop_front(); obs_s = obs_now(); checks++;
      if (obs_s !== exp_s) begin errors++; $display("FAIL go_hit%0d: got %s want %s", hits, fmt(obs_s), fmt(exp_s)); end
    end
    repeat (100) begin
      tick(1);
      if (Firing !== 1'b0 || GameOver !== 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL dead_stuck: got %0d bad frames want 0", seen); end
    sb_q.push_back(mk(640, 480, 10, 0, 1, 0));
    exp_s = sb_q.pop_front(); obs_s = obs_now(); checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL dead_state: got %s want %s", fmt(obs_s), fmt(exp_s)); end
    new_level = 1'b1;
    sb_q.push_back(mk(640, 480, 10, 3, 0, 0));
    tick(1);
    new_level = 1'b0;
    exp_s = sb_q.pop_front(); obs_s = obs_now(); checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL new_level: got %s want %s", fmt(obs_s), fmt(exp_s)); end
    sb_q.push_back(mk(296, 206, 10, 3, 0, 1));
    tick(9);
    exp_s = sb_q.pop_front(); obs_s = obs_now(); checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL level_respawn: got %s want %s", fmt(obs_s), fmt(exp_s)); end
  endtask

`ifdef ENEMY_GUNNER_INVULN_EN
  task automatic test_invuln();
    bit ok;
    setup(300, 200, 260, 195);
    wait_level(1'b1, ok);
    if (ok) wait_level(1'b0, ok);
    if (!ok) begin checks++; errors++; $display("FAIL inv_hit1_timeout: got fire=%0b", Firing); return; end
    sb_q.push_back(mk(640, 480, 9, 3, 0, 0));
    exp_s = sb_q.pop_front(); obs_s = obs_now(); checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL inv_hit1: got %s want %s", fmt(obs_s), fmt(exp_s)); end
    checks++;
    if (PlayerInvuln !== 1'b1) begin errors++; $display("FAIL inv_flag: got %0b want 1", PlayerInvuln); end
    wait_level(1'b1, ok);
    if (ok) wait_level(1'b0, ok);
    if (!ok) begin checks++; errors++; $display("FAIL inv_hit2_timeout: got fire=%0b", Firing); return; end
    sb_q.push_back(mk(640, 480, 9, 3, 0, 0));
    exp_s = sb_q.pop_front(); obs_s = obs_now(); checks++;
    if (obs_s !== exp_s) begin errors++; $display("FAIL inv_hit2: got %s want %s", fmt(obs_s), fmt(exp_s)); end
  endtask
`endif

  initial begin
    Reset = 1'b0;
    new_level = 1'b0;
    test_reset();
    test_left_hit();
    test_aim_abort();
    test_right_edge();
    test_enemy_dead();
    test_game_over();
`ifdef ENEMY_GUNNER_INVULN_EN
    test_invuln();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
